// File: rtl/dbi4_decoder.sv
// Receive-side 4-bit DBI decoder feeding a 2-entry FIFO; 1-cycle latency, in_ready registered (drops when full).
// Optional toggle-rule policing with sticky err is compiled in when DBI4_ERRCHK_EN is defined.
module dbi4_decoder #(
  parameter logic [3:0] RESET_LINE = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] A_in,
  input  logic       dbi_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] A_out,
  output logic       err,
  input  logic       err_clr
);

  logic [3:0] mem [2];
  logic       wptr;
  logic       rptr;
  logic [1:0] occ;
  logic [1:0] occ_nxt;
  logic       push;
  logic       pop;
  logic [3:0] dec;

  assign push  = in_valid & in_ready;
  assign pop   = out_valid & out_ready;
  assign dec   = A_in ^ {4{dbi_in}};
  assign A_out = mem[rptr];

  always_comb begin
    occ_nxt = occ;
    case ({push, pop})
      2'b10:   occ_nxt = occ + 2'd1;
      2'b01:   occ_nxt = occ - 2'd1;
      default: occ_nxt = occ;
    endcase
  end

  // Flags are registered from next occupancy so no path exists from out_ready to in_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0]    <= 4'b0000;
      mem[1]    <= 4'b0000;
      wptr      <= 1'b0;
      rptr      <= 1'b0;
      occ       <= 2'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= dec;
        wptr      <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      occ       <= occ_nxt;
      in_ready  <= (occ_nxt != 2'd2);
      out_valid <= (occ_nxt != 2'd0);
    end
  end

`ifdef DBI4_ERRCHK_EN
  logic [3:0] prev_line;
  logic [3:0] diff;
  logic [2:0] toggles;
  logic       viol;

  assign diff    = A_in ^ prev_line;
  assign toggles = {2'b00, diff[0]} + {2'b00, diff[1]} + {2'b00, diff[2]} + {2'b00, diff[3]};
  assign viol    = push & (toggles > 3'd2);

  // A violation on the same edge as err_clr keeps err set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_line <= RESET_LINE;
      err       <= 1'b0;
    end else begin
      if (push) begin
        prev_line <= A_in;
      end
      err <= viol | (err & ~err_clr);
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^{err_clr, RESET_LINE};
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_dbi4_decoder.sv
// Randomized + directed bench for dbi4_decoder against a queue-based reference model.
module tb_dbi4_decoder;

  localparam logic [3:0] RL = 4'b0000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] A_in;
  logic       dbi_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] A_out;
  logic       err;
  logic       err_clr;

  int checks = 0;
  int errors = 0;

  logic [3:0] q[$];
  logic [3:0] m_prev;
  logic       m_err;

  always #5 clk = ~clk;

  dbi4_decoder #(.RESET_LINE(RL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A_in(A_in), .dbi_in(dbi_in), .out_valid(out_valid), .out_ready(out_ready),
    .A_out(A_out), .err(err), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_prev = RL;
    m_err  = 1'b0;
  endtask

  // Called just after a falling edge: drives inputs, checks outputs, advances one cycle.
  task automatic cycle(input logic v, input logic [3:0] a, input logic d,
                       input logic ordy, input logic clr);
    bit acc, pp, viol;
    in_valid  = v;
    A_in      = a;
    dbi_in    = d;
    out_ready = ordy;
    err_clr   = clr;
    #1;
    chk("in_ready", {7'd0, in_ready}, {7'd0, q.size() < 2});
    chk("out_valid", {7'd0, out_valid}, {7'd0, q.size() != 0});
    if (q.size() != 0) chk("A_out", {4'd0, A_out}, {4'd0, q[0]});
    chk("err", {7'd0, err}, {7'd0, m_err});
    acc  = v && (q.size() < 2);
    pp   = ordy && (q.size() != 0);
    viol = acc && ($countones(a ^ m_prev) > 2);
    @(posedge clk);
    if (pp) void'(q.pop_front());
    if (acc) begin
      q.push_back(a ^ {4{d}});
      m_prev = a;
    end
`ifdef DBI4_ERRCHK_EN
    m_err = viol || (m_err && !clr);
`else
    m_err = 1'b0;
`endif
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; A_in = 4'h0; dbi_in = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
    chk("rst_A_out", {4'd0, A_out}, 8'd0);
    chk("rst_err", {7'd0, err}, 8'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // decode and latency
    cycle(1, 4'b1010, 0, 1, 0);
    chk("dec_plain", {4'd0, A_out}, 8'h0a);
    cycle(1, 4'b1010, 1, 1, 0);
    chk("dec_inv", {4'd0, A_out}, 8'h05);
    cycle(0, 4'h0, 0, 1, 0);
    cycle(0, 4'h0, 0, 1, 0);

    // backpressure: third word held off until a pop frees a slot
    cycle(1, 4'h1, 0, 0, 0);
    cycle(1, 4'h2, 0, 0, 0);
    chk("bp_full", {7'd0, in_ready}, 8'd0);
    cycle(1, 4'h3, 0, 0, 0);
    cycle(1, 4'h3, 0, 1, 0);
    cycle(1, 4'h3, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 4'h0, 0, 1, 0);

    // simultaneous push/pop at occ 1 with out_ready toggling
    begin
      logic [3:0] seq [4] = '{4'h0, 4'h1, 4'h3, 4'h2};
      int k = 0;
      for (int i = 0; i < 20 && k < 4; i++) begin
        if (q.size() < 2) begin
          cycle(1, seq[k], 0, i[0] == 1'b0, 0);
          k++;
        end else begin
          cycle(1, seq[k], 0, i[0] == 1'b0, 0);
        end
      end
      for (int i = 0; i < 4; i++) cycle(0, 4'h0, 0, 1, 0);
      chk("pp_drained", {7'd0, out_valid}, 8'd0);
    end

    // toggle violation then clear-vs-set
    do_reset();
    cycle(1, 4'b0111, 0, 1, 0);
    chk("tv_data", {4'd0, A_out}, 8'h07);
    cycle(1, 4'b0110, 0, 1, 0);
    cycle(1, 4'b0000, 0, 1, 0);
    cycle(1, 4'b1111, 0, 1, 1);
    cycle(0, 4'h0, 0, 1, 1);
    cycle(0, 4'h0, 0, 1, 0);

    // reset mid-operation with the FIFO full, then first word against RESET_LINE
    cycle(1, 4'h9, 0, 0, 0);
    cycle(1, 4'h6, 1, 0, 0);
    chk("mid_full", {7'd0, in_ready}, 8'd0);
    do_reset();
    cycle(1, 4'b1110, 0, 1, 0);
    cycle(0, 4'h0, 0, 1, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 4'($urandom), 1'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0);
      if (i == 200) do_reset();
    end
    for (int i = 0; i < 3; i++) cycle(0, 4'h0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
